// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: one iterative shift-and-add unsigned multiplier shared
// round-robin between two requesters. The granted requester gets a one-cycle
// ack when its operands are captured, and a one-cycle done when its product
// register p is updated, WIDTH edges after the granting edge.
//
// Handshake (valid/ready style, per requester g):
//   req_g is the valid; a_g/b_g must stay stable while req_g is high.
//   The transfer happens on the rising edge where the controller is IDLE and
//   grants g; ack_g is high for exactly the following cycle. The requester
//   drops req_g after seeing ack_g; a req_g still high when the controller is
//   next IDLE is a fresh request. Requests are not looked at during CALC.
//   done_g is high for exactly one cycle, the first cycle p_g holds the new
//   product; p_g is otherwise held.
module mult_share_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  output logic               ack0,
  output logic               done0,
  output logic [2*WIDTH-1:0] p0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack1,
  output logic               done1,
  output logic [2*WIDTH-1:0] p1,
  output logic               busy,
  output logic               owner
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t             state_q;
  state_t             state_d;
  logic               last_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;

  logic               grant_any;
  logic               grant_idx;
  logic               last_iter;
  logic [2*WIDTH-1:0] sum;

  // Arbitration and iteration helpers: a tie goes to the requester not granted last.
  always_comb begin
    grant_any = req0 | req1;
    grant_idx = (req0 && req1) ? ~last_q : req1;
    last_iter = (count_q == CW'(WIDTH - 1));
    sum       = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> CALC on any request, CALC -> IDLE after WIDTH iterations.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = CALC;
      CALC:    if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs; ack/done are single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q   <= 1'b1;
      owner    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      p0       <= '0;
      p1       <= '0;
    end else begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            mcand_q  <= {{WIDTH{1'b0}}, (grant_idx ? a1 : a0)};
            mplier_q <= grant_idx ? b1 : b0;
            acc_q    <= '0;
            count_q  <= '0;
            owner    <= grant_idx;
            last_q   <= grant_idx;
            if (grant_idx) ack1 <= 1'b1;
            else           ack0 <= 1'b1;
          end
        end
        CALC: begin
          acc_q    <= sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          // The final iteration's add goes straight into the owner's product.
          if (last_iter) begin
            if (owner) begin
              p1    <= sum;
              done1 <= 1'b1;
            end else begin
              p0    <= sum;
              done0 <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state: busy doubles as the visible FSM state.
  always_comb begin
    busy = (state_q == CALC);
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed scenarios plus random operands, checked
// against a plain a*b reference with a fixed 8-edge latency.
module tb_mult_share_ctrl;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          ack0, ack1, done0, done1, busy, owner;
  logic [2*W-1:0] p0, p1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*W-1:0] model_p0, model_p1;

  // results from the driver tasks
  int             w_ack_cyc, w_ack_wait, w_done_cyc;
  bit             w_other_ack, w_p_changed, w_other_done, w_busy_low, w_owner_bad, w_any_ack;
  logic           w_busy_at_ack, w_owner_at_ack, w_busy_at_done;
  logic [2*W-1:0] w_prod;

  mult_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0), .done0(done0), .p0(p0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1), .done1(done1), .p1(p1),
    .busy(busy), .owner(owner)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return (2*W)'(a) * (2*W)'(b);
  endfunction

  // Raise req r with operands, wait for its ack, then drop req.
  task automatic issue(input bit r, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    if (r) begin req1 = 1'b1; a1 = a; b1 = b; end
    else   begin req0 = 1'b1; a0 = a; b0 = b; end
    w_ack_cyc = -1; w_ack_wait = 0; w_other_ack = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (r ? ack0 : ack1) w_other_ack = 1;
      if (r ? ack1 : ack0) begin w_ack_cyc = cyc; w_ack_wait = i; break; end
    end
    w_busy_at_ack  = busy;
    w_owner_at_ack = owner;
    if (r) req1 = 1'b0; else req0 = 1'b0;
  endtask

  // Wait for done of requester r, watching p, busy, owner and the other port.
  task automatic wait_done(input bit r);
    logic [2*W-1:0] p_start;
    p_start = r ? p1 : p0;
    w_done_cyc = -1; w_prod = 'x; w_busy_at_done = 1'bx;
    w_p_changed = 0; w_other_done = 0; w_busy_low = 0; w_owner_bad = 0; w_any_ack = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (r ? done0 : done1) w_other_done = 1;
      if (owner !== r) w_owner_bad = 1;
      if (ack0 || ack1) w_any_ack = 1;
      if (r ? done1 : done0) begin
        w_done_cyc = cyc; w_prod = r ? p1 : p0; w_busy_at_done = busy;
        break;
      end
      if ((r ? p1 : p0) !== p_start) w_p_changed = 1;
      if (busy !== 1'b1) w_busy_low = 1;
    end
    if (w_done_cyc < 0) $display("FAIL done_timeout req=%0d no done within 40 cycles", r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_p0 = '0; model_p1 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    model_p0 = '0; model_p1 = '0;
    repeat (2) @(negedge clk);
    total++; if (ack0 !== 1'b0)  begin bad++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
    total++; if (ack1 !== 1'b0)  begin bad++; $display("FAIL reset_ack1 got=%b exp=0", ack1); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done0 got=%b exp=0", done0); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done1 got=%b exp=0", done1); end
    total++; if (p0 !== 16'd0)   begin bad++; $display("FAIL reset_p0 got=%h exp=0", p0); end
    total++; if (p1 !== 16'd0)   begin bad++; $display("FAIL reset_p1 got=%h exp=0", p1); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b exp=0", owner); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    issue(0, 8'd3, 8'd5);
    total++; if (w_ack_wait !== 1) begin bad++; $display("FAIL basic_ack_wait got=%0d exp=1", w_ack_wait); end
    total++; if (w_other_ack !== 0) begin bad++; $display("FAIL basic_ack1 got=1 exp=0"); end
    total++; if (w_busy_at_ack !== 1'b1) begin bad++; $display("FAIL basic_busy_ack got=%b exp=1", w_busy_at_ack); end
    wait_done(0);
    total++; if (w_done_cyc - w_ack_cyc !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", w_done_cyc - w_ack_cyc); end
    total++; if (w_prod !== 16'h000F) begin bad++; $display("FAIL basic_p0 got=%h exp=000f", w_prod); end
    total++; if (w_busy_low !== 0) begin bad++; $display("FAIL basic_busy_calc got=low exp=high"); end
    total++; if (w_busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_done got=%b exp=0", w_busy_at_done); end
    total++; if (w_other_done !== 0) begin bad++; $display("FAIL basic_done1 got=1 exp=0"); end
    total++; if (p1 !== model_p1) begin bad++; $display("FAIL basic_p1 got=%h exp=%h", p1, model_p1); end
    model_p0 = 16'h000F;
  endtask

  task automatic test_req1();
    issue(1, 8'd255, 8'd255);
    total++; if (w_owner_at_ack !== 1'b1) begin bad++; $display("FAIL req1_owner_ack got=%b exp=1", w_owner_at_ack); end
    wait_done(1);
    total++; if (w_owner_bad !== 0) begin bad++; $display("FAIL req1_owner_calc got=not1 exp=1"); end
    total++; if (w_done_cyc - w_ack_cyc !== 8) begin bad++; $display("FAIL req1_latency got=%0d exp=8", w_done_cyc - w_ack_cyc); end
    total++; if (w_prod !== 16'hFE01) begin bad++; $display("FAIL req1_p1 got=%h exp=fe01", w_prod); end
    total++; if (p0 !== model_p0) begin bad++; $display("FAIL req1_p0_kept got=%h exp=%h", p0, model_p0); end
    model_p1 = 16'hFE01;
  endtask

  task automatic test_tie();
    int ack1_cyc;
    bit saw_ack0;
    do_reset();
    @(negedge clk);
    req0 = 1; a0 = 8'd12; b0 = 8'd10;
    req1 = 1; a1 = 8'd7;  b1 = 8'd9;
    saw_ack0 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack1) break;
      if (ack0) begin saw_ack0 = 1; w_ack_cyc = cyc; break; end
    end
    total++; if (saw_ack0 !== 1) begin bad++; $display("FAIL tie_first_grant got=not0 exp=0"); end
    req0 = 0;
    wait_done(0);
    total++; if (w_prod !== 16'd120) begin bad++; $display("FAIL tie_p0 got=%0d exp=120", w_prod); end
    total++; if (w_any_ack !== 0) begin bad++; $display("FAIL tie_ack_in_calc got=1 exp=0"); end
    ack1_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack1) begin ack1_cyc = cyc; break; end
    end
    total++; if (ack1_cyc !== w_done_cyc + 1) begin bad++; $display("FAIL tie_ack1_cycle got=%0d exp=%0d", ack1_cyc, w_done_cyc + 1); end
    req1 = 0;
    w_ack_cyc = ack1_cyc;
    wait_done(1);
    total++; if (w_prod !== 16'd63) begin bad++; $display("FAIL tie_p1 got=%0d exp=63", w_prod); end
    model_p0 = 16'd120; model_p1 = 16'd63;
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] exp0_q[$];
    logic [2*W-1:0] exp1_q[$];
    int order_q[$];
    int ack_cyc_q[$];
    int grants, dones;
    logic [2*W-1:0] e;
    grants = 0; dones = 0;
    @(negedge clk);
    req0 = 1; a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
    req1 = 1; a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
    for (int i = 0; i < 120 && dones < 4; i++) begin
      @(negedge clk);
      if (done0) begin
        dones++;
        total++;
        if (exp0_q.size() == 0) begin bad++; $display("FAIL b2b_p0 unexpected done0 p0=%h", p0); end
        else begin
          e = exp0_q.pop_front();
          if (p0 !== e) begin bad++; $display("FAIL b2b_p0 got=%h exp=%h", p0, e); end
          model_p0 = e;
        end
      end
      if (done1) begin
        dones++;
        total++;
        if (exp1_q.size() == 0) begin bad++; $display("FAIL b2b_p1 unexpected done1 p1=%h", p1); end
        else begin
          e = exp1_q.pop_front();
          if (p1 !== e) begin bad++; $display("FAIL b2b_p1 got=%h exp=%h", p1, e); end
          model_p1 = e;
        end
      end
      if (ack0 || ack1) begin
        grants++;
        order_q.push_back(ack1 ? 1 : 0);
        ack_cyc_q.push_back(cyc);
        if (ack0) begin
          exp0_q.push_back(ref_mul(a0, b0));
          a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
        end else begin
          exp1_q.push_back(ref_mul(a1, b1));
          a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
        end
        if (grants >= 4) begin req0 = 0; req1 = 0; end
      end
    end
    req0 = 0; req1 = 0;
    total++; if (dones !== 4) begin bad++; $display("FAIL b2b_done_count got=%0d exp=4", dones); end
    total++; if (order_q.size() !== 4) begin bad++; $display("FAIL b2b_grant_count got=%0d exp=4", order_q.size()); end
    for (int k = 0; k < order_q.size() && k < 4; k++) begin
      total++;
      if (order_q[k] !== k % 2) begin bad++; $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", k, order_q[k], k % 2); end
    end
    for (int k = 1; k < ack_cyc_q.size(); k++) begin
      total++;
      if (ack_cyc_q[k] - ack_cyc_q[k-1] !== 9) begin bad++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=9", k, ack_cyc_q[k] - ack_cyc_q[k-1]); end
    end
  endtask

  task automatic test_zero();
    issue(0, 8'h00, 8'hAB);
    wait_done(0);
    total++; if (w_done_cyc - w_ack_cyc !== 8) begin bad++; $display("FAIL zero_a_latency got=%0d exp=8", w_done_cyc - w_ack_cyc); end
    total++; if (w_prod !== 16'd0) begin bad++; $display("FAIL zero_a_p0 got=%h exp=0", w_prod); end
    issue(0, 8'hAB, 8'h00);
    wait_done(0);
    total++; if (w_done_cyc - w_ack_cyc !== 8) begin bad++; $display("FAIL zero_b_latency got=%0d exp=8", w_done_cyc - w_ack_cyc); end
    total++; if (w_prod !== 16'd0) begin bad++; $display("FAIL zero_b_p0 got=%h exp=0", w_prod); end
    model_p0 = '0;
  endtask

  task automatic test_hold();
    issue(0, 8'd3, 8'd5);
    wait_done(0);
    total++; if (w_prod !== 16'd15) begin bad++; $display("FAIL hold_first got=%0d exp=15", w_prod); end
    issue(0, 8'd6, 8'd7);
    total++; if (p0 !== 16'd15) begin bad++; $display("FAIL hold_at_ack got=%0d exp=15", p0); end
    wait_done(0);
    total++; if (w_p_changed !== 0) begin bad++; $display("FAIL hold_early_change got=changed exp=15"); end
    total++; if (w_prod !== 16'd42) begin bad++; $display("FAIL hold_final got=%0d exp=42", w_prod); end
    model_p0 = 16'd42;
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    issue(0, 8'd20, 8'd20);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (p0 !== 16'd0)  begin bad++; $display("FAIL abort_p0 got=%h exp=0", p0); end
    total++; if (p1 !== 16'd0)  begin bad++; $display("FAIL abort_p1 got=%h exp=0", p1); end
    @(negedge clk);
    reset = 1'b0;
    model_p0 = '0; model_p1 = '0;
    saw_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done0 || done1) saw_done = 1;
    end
    total++; if (saw_done !== 0) begin bad++; $display("FAIL abort_no_done got=done exp=none"); end
    issue(0, 8'd2, 8'd2);
    wait_done(0);
    total++; if (w_prod !== 16'd4) begin bad++; $display("FAIL abort_next_p0 got=%0d exp=4", w_prod); end
    total++; if (w_done_cyc - w_ack_cyc !== 8) begin bad++; $display("FAIL abort_next_latency got=%0d exp=8", w_done_cyc - w_ack_cyc); end
    model_p0 = 16'd4;
  endtask

  task automatic test_random();
    bit r;
    logic [W-1:0] a, b;
    logic [2*W-1:0] e;
    for (int n = 0; n < 12; n++) begin
      r = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      e = ref_mul(a, b);
      issue(r, a, b);
      wait_done(r);
      total++; if (w_prod !== e) begin bad++; $display("FAIL rand_prod n=%0d req=%0d a=%0d b=%0d got=%0d exp=%0d", n, r, a, b, w_prod, e); end
      total++; if (w_done_cyc - w_ack_cyc !== 8) begin bad++; $display("FAIL rand_latency n=%0d got=%0d exp=8", n, w_done_cyc - w_ack_cyc); end
      total++;
      if ((r ? p0 : p1) !== (r ? model_p0 : model_p1)) begin
        bad++; $display("FAIL rand_other_p n=%0d got=%h exp=%h", n, (r ? p0 : p1), (r ? model_p0 : model_p1));
      end
      total++; if (w_other_done !== 0) begin bad++; $display("FAIL rand_other_done n=%0d got=1 exp=0", n); end
      if (r) model_p1 = e; else model_p0 = e;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req1();
    test_tie();
    test_back_to_back();
    test_zero();
    test_hold();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
Controller that shares one iterative shift-and-add unsigned multiplier between two requesters. It arbitrates round-robin, captures the granted requester's operands with a one-cycle ack, and runs WIDTH add/shift iterations. It then returns the 2*WIDTH-bit product to that requester with a one-cycle done pulse. It replaces the per-operand registered combinational multiply in the switch/LED/7-segment lab top, and frees the multiplier for a second client.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
req0  input  1  requester 0 request; held high with a0/b0 stable until ack0.
a0  input  WIDTH  requester 0 multiplicand.
b0  input  WIDTH  requester 0 multiplier.
ack0  output  1  one-cycle pulse: requester 0 operands captured.
done0  output  1  one-cycle pulse: p0 updated with a new product.
p0  output  2*WIDTH  requester 0 product; holds until its next done0.
req1, a1, b1, ack1, done1, p1: identical to the requester 0 ports, for requester 1.
busy  output  1  high whenever state is not IDLE.
owner  output  1  index of the requester currently or last granted.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE.
  - ack0/ack1/done0/done1=0, p0=p1=0, busy=0, owner=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Internal accumulator, multiplicand, multiplier and counter registers are cleared.
- Reset asserted mid-operation aborts the operation: no done is produced and the result is lost.
- States: IDLE, CALC.
- IDLE, on a rising edge:
  - Only req0 high: grant 0.
  - Only req1 high: grant 1.
  - Both high: grant the index not equal to last.
  - On grant:
    - Capture mcand={WIDTH zeros, a_g}, mplier=b_g, acc=0, count=0.
    - Set owner=g and last=g.
    - Assert ack_g high for exactly the next cycle; go to CALC.
  - Neither req high: stay in IDLE.
- CALC, on each rising edge:
  - If mplier[0]=1, acc <= acc + mcand.
  - mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
- On the WIDTH-th CALC edge:
  - Write the final sum (including that iteration's add) directly to p_owner.
  - Assert done_owner high for exactly the next cycle.
  - Return to IDLE.
  - The other requester's p and done are untouched.
- Latency and throughput:
  - Exactly WIDTH clock edges from the granting edge to the edge that raises done.
  - Fixed latency, independent of operand values, including zero operands.
  - A new grant may occur on the edge after the done edge, giving one product per WIDTH+1 cycles when requests are continuous.
- Requests are ignored while in CALC.
- Handshake rules:
  - The requester drops req on the edge after seeing ack.
  - req still high when the block next samples in IDLE is treated as a new request.
- Arithmetic:
  - Unsigned. acc is 2*WIDTH bits and cannot overflow, since max is (2^W-1)^2.
- ack and done are registered outputs, never combinational from req.
- busy is high from the cycle after the grant edge through the cycle of the WIDTH-th CALC edge, and low in the cycle done is high.
- owner holds its value in IDLE.

Test Plan:
1. reset, then req0=1, a0=3, b0=5 -> ack0 high 1 cycle after the grant edge; done0 high 8 edges after grant; p0=15 (0x000F); done1=0, p1=0.
2. req1 with a1=255, b1=255 -> p1=65025 (0xFE01) with the same 8-edge latency; owner=1 during CALC.
3. After reset, req0 and req1 raised on the same cycle (a0=12, b0=10, a1=7, b1=9) and held until each ack:
   - requester 0 granted first, p0=120;
   - requester 1 granted on the edge after done0, p1=63;
   - both requests held continuously thereafter alternate 0,1,0,1.
4. a0=0x00, b0=0xAB -> p0=0, done0 still exactly 8 edges after grant; same latency for a0=0xAB, b0=0x00.
5. Assert reset 4 cycles into CALC of a req0 (a0=20, b0=20) -> busy=0, p0=0, no done0 ever; the following req0 (a0=2, b0=2) completes with p0=4.
6. Completed p0=15, then a new req0 (a0=6, b0=7) -> p0 stays 15 until the done0 cycle, then becomes 42.
